// File: rtl/buzzer_tone_module.sv
// buzzer_tone_module
//   Square-wave tone generator for a passive buzzer. It sits downstream of the
//   SOS/pattern generator. While Tone_En is high, the block emits periods of
//   P[Tone_Sel] clocks. Each period is high for (P>>4)*(Vol+1) clocks and low
//   for the rest of the period. A period is never cut short: dropping Tone_En
//   only takes effect at the next period boundary.
//
//   Optional build macro BUZZER_WDT_EN adds a watchdog. After WDT_MS ms of
//   continuous Tone_En, the block finishes the current period and then stays
//   silent until Tone_En has been low for at least one cycle.
//
// Ports
//   CLK        in   system clock (50 MHz nominal)
//   RSTn       in   synchronous, active-low reset
//   Tone_En    in   gate, 1 = sound requested
//   Tone_Sel   in   [1:0] period select, sampled at period start only
//   Vol        in   [2:0] duty select, sampled at period start only
//   Buzzer_Out out  registered square wave
//   Busy       out  registered, high while a period is in progress
module buzzer_tone_module #(
  parameter logic [15:0] P0     = 16'd25_000,
  parameter logic [15:0] P1     = 16'd20_000,
  parameter logic [15:0] P2     = 16'd16_667,
  parameter logic [15:0] P3     = 16'd12_500,
  parameter logic [15:0] T1MS   = 16'd49_999,
  parameter logic [11:0] WDT_MS = 12'd2000
) (
  input  logic       CLK,
  input  logic       RSTn,
  input  logic       Tone_En,
  input  logic [1:0] Tone_Sel,
  input  logic [2:0] Vol,
  output logic       Buzzer_Out,
  output logic       Busy
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] p_lat_q, p_lat_d;
  logic [15:0] hi_lat_q, hi_lat_d;
  logic        out_q, out_d;
  logic        busy_q, busy_d;

  logic [15:0] p_sel;
  logic [15:0] hi_sel;
  logic        wdt_block;
  logic        start_ok;
  logic        period_end;

  always_comb begin
    unique case (Tone_Sel)
      2'd0:    p_sel = P0;
      2'd1:    p_sel = P1;
      2'd2:    p_sel = P2;
      default: p_sel = P3;
    endcase
  end

  // High time is a whole number of sixteenths of the period. The largest
  // value is 4095*8, so the result fits in 16 bits.
  assign hi_sel = (p_sel >> 4) * (16'(Vol) + 16'd1);

`ifdef BUZZER_WDT_EN
  logic [15:0] pre_q, pre_d;
  logic [11:0] ms_q, ms_d;
  logic        trip_q, trip_d;

  // The counters run only while the gate is held. They freeze once tripped.
  // Any low cycle on the gate re-arms the watchdog.
  always_comb begin
    pre_d  = pre_q;
    ms_d   = ms_q;
    trip_d = trip_q | (ms_q == WDT_MS);
    if (!Tone_En) begin
      pre_d  = '0;
      ms_d   = '0;
      trip_d = 1'b0;
    end else if (!trip_d) begin
      if (pre_q == T1MS) begin
        pre_d = '0;
        ms_d  = ms_q + 12'd1;
      end else begin
        pre_d = pre_q + 16'd1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      pre_q  <= '0;
      ms_q   <= '0;
      trip_q <= 1'b0;
    end else begin
      pre_q  <= pre_d;
      ms_q   <= ms_d;
      trip_q <= trip_d;
    end
  end

  assign wdt_block = trip_q | (ms_q == WDT_MS);
`else
  logic unused_wdt_params;
  assign unused_wdt_params = ^{T1MS, WDT_MS};
  assign wdt_block = 1'b0;
`endif

  assign start_ok   = Tone_En & ~wdt_block;
  assign period_end = (cnt_q == p_lat_q - 16'd1);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    p_lat_d  = p_lat_q;
    hi_lat_d = hi_lat_q;
    out_d    = out_q;
    busy_d   = busy_q;
    unique case (state_q)
      IDLE: begin
        out_d  = 1'b0;
        busy_d = 1'b0;
        if (start_ok) begin
          state_d  = RUN;
          p_lat_d  = p_sel;
          hi_lat_d = hi_sel;
          cnt_d    = '0;
          out_d    = 1'b1;
          busy_d   = 1'b1;
        end
      end
      default: begin
        if (period_end) begin
          // The next period follows with no gap cycle, using freshly
          // sampled selects.
          if (start_ok) begin
            p_lat_d  = p_sel;
            hi_lat_d = hi_sel;
            cnt_d    = '0;
            out_d    = 1'b1;
            busy_d   = 1'b1;
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
            out_d   = 1'b0;
            busy_d  = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
          out_d = (cnt_d < hi_lat_q);
        end
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      p_lat_q  <= '0;
      hi_lat_q <= '0;
      out_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      p_lat_q  <= p_lat_d;
      hi_lat_q <= hi_lat_d;
      out_q    <= out_d;
      busy_q   <= busy_d;
    end
  end

  assign Buzzer_Out = out_q;
  assign Busy       = busy_q;

endmodule
